// File: rtl/servo_ramp_ctrl_pkg.sv
// Shared types and default constants for the servo position sequencer.
// Preset widths are derived from the endpoint widths with integer truncation.
package servo_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MOVE   = 2'd1,
      SETTLE = 2'd2
   } servo_state_t;

   localparam int unsigned DEF_FRAME_CYCLES  = 1_000_000;
   localparam int unsigned DEF_PW_MIN        = 50_000;
   localparam int unsigned DEF_PW_MAX        = 100_000;
   localparam int unsigned DEF_STEP          = 500;
   localparam int unsigned DEF_SETTLE_FRAMES = 5;
   localparam int unsigned DEF_W             = 20;
   localparam int unsigned POS_W             = 2;
   localparam int unsigned NUM_PRESETS       = 4;

   function automatic int unsigned preset_pw(input int unsigned pw_min,
                                             input int unsigned pw_max,
                                             input int unsigned idx);
      return pw_min + (idx * (pw_max - pw_min)) / 3;
   endfunction

endpackage

// File: rtl/servo_ramp_ctrl_if.sv
// Command handshake and status bundle between the control logic and the servo sequencer.
interface servo_ramp_ctrl_if;
   import servo_pkg::*;

   logic             enable;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [POS_W-1:0] cmd_pos;
   logic             servo;
   logic             busy;
   logic             at_target;
   logic             frame_tick;

   modport master (
      output enable, cmd_valid, cmd_pos,
      input  cmd_ready, servo, busy, at_target, frame_tick
   );

   modport slave (
      input  enable, cmd_valid, cmd_pos,
      output cmd_ready, servo, busy, at_target, frame_tick
   );

endinterface

// File: rtl/servo_ramp_ctrl_pwm_gen.sv
// Free-running PWM frame counter with a registered pulse output; the pulse is
// high for i_cur_pw cycles starting one cycle after the counter reads zero.
module servo_pwm_gen
   import servo_pkg::*;
#(
   parameter int unsigned FRAME_CYCLES = DEF_FRAME_CYCLES,
   parameter int unsigned W            = DEF_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_enable,
   input  logic [W-1:0] i_cur_pw,
   output logic         o_servo,
   output logic         o_frame_tick
);

   localparam logic [W-1:0] LAST_CNT = W'(FRAME_CYCLES - 1);

   logic [W-1:0] r_frame_cnt;
   logic         r_servo;
   logic         w_last;

   assign w_last = (r_frame_cnt == LAST_CNT);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_cnt <= '0;
         r_servo     <= 1'b0;
      end else begin
         r_frame_cnt <= w_last ? '0 : r_frame_cnt + 1'b1;
         r_servo     <= i_enable && (r_frame_cnt < i_cur_pw);
      end
   end

   assign o_servo      = r_servo;
   assign o_frame_tick = w_last;

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Servo position sequencer: accepts a preset index, ramps the pulse width by at
// most STEP per frame toward it, then holds for SETTLE_FRAMES before re-arming.
module servo_ramp_ctrl
   import servo_pkg::*;
#(
   parameter int unsigned FRAME_CYCLES  = DEF_FRAME_CYCLES,
   parameter int unsigned PW_MIN        = DEF_PW_MIN,
   parameter int unsigned PW_MAX        = DEF_PW_MAX,
   parameter int unsigned STEP          = DEF_STEP,
   parameter int unsigned SETTLE_FRAMES = DEF_SETTLE_FRAMES,
   parameter int unsigned W             = DEF_W
) (
   input logic              clk,
   input logic              rst,
   servo_ramp_ctrl_if.slave bus
);

   localparam int unsigned SC_W = $clog2(SETTLE_FRAMES + 1);
   localparam logic [W-1:0] PRESET [NUM_PRESETS] = '{
      W'(preset_pw(PW_MIN, PW_MAX, 0)),
      W'(preset_pw(PW_MIN, PW_MAX, 1)),
      W'(preset_pw(PW_MIN, PW_MAX, 2)),
      W'(preset_pw(PW_MIN, PW_MAX, 3))
   };
   localparam logic signed [W:0] STEP_S = (W+1)'(STEP);

   servo_state_t        r_state, w_next_state;
   logic [W-1:0]        r_cur_pw, r_tgt_pw;
   logic [SC_W-1:0]     r_settle_cnt;
   logic signed [W:0]   w_diff, w_abs_diff;
   logic                w_accept, w_advance, w_close, w_settle_done;
   logic                w_frame_tick, w_servo, w_cmd_ready, w_busy;

   servo_pwm_gen #(.FRAME_CYCLES(FRAME_CYCLES), .W(W)) u_pwm (
      .clk          (clk),
      .rst          (rst),
      .i_enable     (bus.enable),
      .i_cur_pw     (r_cur_pw),
      .o_servo      (w_servo),
      .o_frame_tick (w_frame_tick)
   );

   // Extra sign bit keeps the distance exact in both directions.
   assign w_diff        = $signed({1'b0, r_tgt_pw}) - $signed({1'b0, r_cur_pw});
   assign w_abs_diff    = w_diff[W] ? -w_diff : w_diff;
   assign w_close       = (w_abs_diff <= STEP_S);
   assign w_accept      = bus.cmd_valid && (r_state == IDLE);
   assign w_advance     = w_frame_tick && bus.enable;
   assign w_settle_done = (r_settle_cnt == SC_W'(SETTLE_FRAMES - 1));

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   // NOTE: defaulting before the case keeps every path assigned, so no latch.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_accept)                   w_next_state = MOVE;
         MOVE:    if (w_advance && w_close)       w_next_state = SETTLE;
         SETTLE:  if (w_advance && w_settle_done) w_next_state = IDLE;
         default:                                 w_next_state = IDLE;
      endcase
   end

   always_comb begin
      w_cmd_ready = (r_state == IDLE);
      w_busy      = (r_state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cur_pw     <= W'(PW_MIN);
         r_tgt_pw     <= W'(PW_MIN);
         r_settle_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_accept) r_tgt_pw <= PRESET[bus.cmd_pos];
            MOVE: if (w_advance) begin
               if (w_close) begin
                  r_cur_pw     <= r_tgt_pw;
                  r_settle_cnt <= '0;
               end else if (w_diff[W]) begin
                  r_cur_pw <= r_cur_pw - W'(STEP);
               end else begin
                  r_cur_pw <= r_cur_pw + W'(STEP);
               end
            end
            SETTLE: if (w_advance) r_settle_cnt <= r_settle_cnt + 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.cmd_ready  = w_cmd_ready;
   assign bus.busy       = w_busy;
   assign bus.servo      = w_servo;
   assign bus.frame_tick = w_frame_tick;
   assign bus.at_target  = (r_cur_pw == r_tgt_pw);

endmodule
